rom_port_arbiter: RTL and testbench



---
 rtl/rom_port_arbiter_if.sv | 26 ++
 rtl/rom_port_arbiter.sv | 86 ++++++++
 tb/tb_rom_port_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if: requester ports and ROM port shared by the arbiter and its environment.
interface rom_port_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  cpu_req;
  logic [15:0]           cpu_addr;
  logic                  cpu_ack;
  logic [DATA_WIDTH-1:0] cpu_data;
  logic                  pnl_req;
  logic [15:0]           pnl_addr;
  logic                  pnl_ack;
  logic [DATA_WIDTH-1:0] pnl_data;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_rd;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  busy;
  modport slave (
    input  cpu_req, cpu_addr, pnl_req, pnl_addr, rom_data,
    output cpu_ack, cpu_data, pnl_ack, pnl_data, rom_addr, rom_rd, busy
  );
  modport master (
    output cpu_req, cpu_addr, pnl_req, pnl_addr, rom_data,
    input  cpu_ack, cpu_data, pnl_ack, pnl_data, rom_addr, rom_rd, busy
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares a synchronous-read ROM between the CPU and front panel,
// CPU priority with a bounded number of CPU grants while the panel waits.
module rom_port_arbiter #(
  parameter int          ADDR_WIDTH   = 8,
  parameter int          DATA_WIDTH   = 8,
  parameter logic [15:0] BASE_ADDR    = 16'hFD00,
  parameter int          STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset_n,
  rom_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, READ, CAPT, ACK} state_t;
  state_t                r_state, w_next;
  logic [SW-1:0]         r_starve;
  logic                  r_owner;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic                  r_rom_rd;
  logic                  r_cpu_ack, r_pnl_ack;
  logic [DATA_WIDTH-1:0] r_cpu_data, r_pnl_data;
  logic                  w_grant, w_pnl_win, w_hit;
  logic [15:0]           w_addr;
  always_comb begin
    w_grant   = r_state == IDLE && (bus.cpu_req || bus.pnl_req);
    w_pnl_win = !bus.cpu_req || (r_starve == LIM && bus.pnl_req);
    w_addr    = w_pnl_win ? bus.pnl_addr : bus.cpu_addr;
    w_hit     = w_addr[15:ADDR_WIDTH] == BASE_ADDR[15:ADDR_WIDTH];
    w_next    = r_state == IDLE ? (w_grant ? (w_hit ? READ : ACK) : IDLE) :
                r_state == READ ? CAPT :
                r_state == CAPT ? ACK : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve   <= '0;
      r_owner    <= 1'b0;
      r_rom_addr <= '0;
      r_rom_rd   <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_pnl_ack  <= 1'b0;
      r_cpu_data <= '0;
      r_pnl_data <= '0;
    end else begin
      if (w_grant && w_hit) begin
        r_rom_addr <= w_addr[ADDR_WIDTH-1:0];
        r_rom_rd   <= 1'b1;
        r_owner    <= w_pnl_win;
      end
      // Misses complete immediately with all-ones and never touch the ROM
      if (w_grant && !w_hit && w_pnl_win) begin
        r_pnl_data <= '1;
        r_pnl_ack  <= 1'b1;
      end
      if (w_grant && !w_hit && !w_pnl_win) begin
        r_cpu_data <= '1;
        r_cpu_ack  <= 1'b1;
      end
      if (r_state == READ) r_rom_rd <= 1'b0;
      if (r_state == CAPT && r_owner) begin
        r_pnl_data <= bus.rom_data;
        r_pnl_ack  <= 1'b1;
      end
      if (r_state == CAPT && !r_owner) begin
        r_cpu_data <= bus.rom_data;
        r_cpu_ack  <= 1'b1;
      end
      if (r_state == ACK) begin
        r_cpu_ack <= 1'b0;
        r_pnl_ack <= 1'b0;
      end
      if (r_state == IDLE && (!bus.pnl_req || (w_grant && w_pnl_win))) r_starve <= '0;
      else if (w_grant && r_starve != LIM) r_starve <= r_starve + SW'(1);
    end
  end
  assign bus.rom_addr = r_rom_addr;
  assign bus.rom_rd   = r_rom_rd;
  assign bus.cpu_ack  = r_cpu_ack;
  assign bus.cpu_data = r_cpu_data;
  assign bus.pnl_ack  = r_pnl_ack;
  assign bus.pnl_data = r_pnl_data;
  assign bus.busy     = r_state != IDLE;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: cycle vectors plus directed arbitration, starvation and reset sequences.
module tb_rom_port_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  rom_port_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();
  rom_port_arbiter #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .BASE_ADDR(16'hFD00), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  always #5 clk = ~clk;
  logic [7:0] mem [256];
  always @(posedge clk) if (bus.rom_rd) bus.rom_data <= mem[bus.rom_addr];
  typedef struct {
    logic        cr;
    logic [15:0] ca;
    logic        pr;
    logic [15:0] pa;
    logic        cack;
    logic [7:0]  cdata;
    logic        pack;
    logic [7:0]  pdata;
    logic        rd;
    logic        busy;
  } vec_t;
  vec_t v [24];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  task automatic wait_ack(input bit pnl, input int max, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= max && !seen; i++) begin
      step();
      if (pnl ? bus.pnl_ack : bus.cpu_ack) begin
        seen = 1'b1;
        n = i;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_ack_timeout actual=none expected=ack within %0d", pnl ? "pnl" : "cpu", max);
    end
  endtask
  function automatic logic [19:0] outs();
    return {bus.cpu_ack, bus.cpu_data, bus.pnl_ack, bus.pnl_data, bus.rom_rd, bus.busy};
  endfunction
  initial begin
    int n;
    int ncpu;
    bit done;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h00] = 8'h3E;
    mem[8'h02] = 8'hD3;
    mem[8'hFF] = 8'hC9;
    v[0]  = '{1'b1, 16'hFD00, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1};
    v[1]  = '{1'b1, 16'hFD00, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    v[2]  = '{1'b1, 16'hFD00, 1'b0, 16'h0000, 1'b1, 8'h3E, 1'b0, 8'h00, 1'b0, 1'b1};
    v[3]  = '{1'b1, 16'hFD00, 1'b0, 16'h0000, 1'b0, 8'h3E, 1'b0, 8'h00, 1'b0, 1'b0};
    v[4]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h3E, 1'b0, 8'h00, 1'b0, 1'b0};
    v[5]  = '{1'b0, 16'h0000, 1'b1, 16'hFDFF, 1'b0, 8'h3E, 1'b0, 8'h00, 1'b1, 1'b1};
    v[6]  = '{1'b0, 16'h0000, 1'b1, 16'hFDFF, 1'b0, 8'h3E, 1'b0, 8'h00, 1'b0, 1'b1};
    v[7]  = '{1'b0, 16'h0000, 1'b1, 16'hFDFF, 1'b0, 8'h3E, 1'b1, 8'hC9, 1'b0, 1'b1};
    v[8]  = '{1'b0, 16'h0000, 1'b1, 16'hFDFF, 1'b0, 8'h3E, 1'b0, 8'hC9, 1'b0, 1'b0};
    v[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h3E, 1'b0, 8'hC9, 1'b0, 1'b0};
    v[10] = '{1'b1, 16'h1234, 1'b0, 16'h0000, 1'b1, 8'hFF, 1'b0, 8'hC9, 1'b0, 1'b1};
    v[11] = '{1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 8'hFF, 1'b0, 8'hC9, 1'b0, 1'b0};
    v[12] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'hFF, 1'b0, 8'hC9, 1'b0, 1'b0};
    v[13] = '{1'b0, 16'h0000, 1'b1, 16'hFC00, 1'b0, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b1};
    v[14] = '{1'b0, 16'h0000, 1'b1, 16'hFC00, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0};
    v[15] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0};
    v[16] = '{1'b1, 16'hFE00, 1'b0, 16'h0000, 1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1};
    v[17] = '{1'b1, 16'hFE00, 1'b0, 16'h0000, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0};
    v[18] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0};
    v[19] = '{1'b1, 16'hFDFF, 1'b0, 16'h0000, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b1};
    v[20] = '{1'b1, 16'hFDFF, 1'b0, 16'h0000, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1};
    v[21] = '{1'b1, 16'hFDFF, 1'b0, 16'h0000, 1'b1, 8'hC9, 1'b0, 8'hFF, 1'b0, 1'b1};
    v[22] = '{1'b1, 16'hFDFF, 1'b0, 16'h0000, 1'b0, 8'hC9, 1'b0, 8'hFF, 1'b0, 1'b0};
    v[23] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'hC9, 1'b0, 8'hFF, 1'b0, 1'b0};
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.pnl_req = 1'b0; bus.pnl_addr = '0;
    step();
    step();
    chk("reset_outputs", 32'(outs()), 32'h0);
    chk("reset_rom_addr", 32'(bus.rom_addr), 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bus.cpu_req = v[i].cr; bus.cpu_addr = v[i].ca;
      bus.pnl_req = v[i].pr; bus.pnl_addr = v[i].pa;
      step();
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({v[i].cack, v[i].cdata, v[i].pack, v[i].pdata, v[i].rd, v[i].busy}));
    end
    // simultaneous requests: CPU first, panel at the next idle
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'hFD00;
    bus.pnl_req = 1'b1; bus.pnl_addr = 16'hFD02;
    wait_ack(1'b0, 10, n);
    chk("sim_cpu_latency", 32'(n), 32'd3);
    chk("sim_cpu_data", 32'(bus.cpu_data), 32'h3E);
    chk("sim_pnl_ack_low", 32'(bus.pnl_ack), 32'h0);
    step();
    bus.cpu_req = 1'b0;
    wait_ack(1'b1, 10, n);
    chk("sim_pnl_latency", 32'(n), 32'd3);
    chk("sim_pnl_data", 32'(bus.pnl_data), 32'hD3);
    chk("sim_cpu_data_kept", 32'(bus.cpu_data), 32'h3E);
    step();
    bus.pnl_req = 1'b0;
    step();
    // CPU held continuously while the panel waits
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'hFD00;
    bus.pnl_req = 1'b1; bus.pnl_addr = 16'hFD02;
    ncpu = 0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (bus.cpu_ack) ncpu++;
      if (bus.pnl_ack) done = 1'b1;
    end
    chk("starve_pnl_acked", 32'(done), 32'h1);
    chk("starve_cpu_grants", 32'(ncpu), 32'd4);
    chk("starve_pnl_data", 32'(bus.pnl_data), 32'hD3);
    chk("starve_counter_clear", 32'(dut.r_starve), 32'h0);
    step();
    bus.cpu_req = 1'b0; bus.pnl_req = 1'b0;
    step();
    step();
    // reset while the read data is being captured
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'hFD00;
    step();
    step();
    chk("pre_reset_busy", 32'(bus.busy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_outputs", 32'(outs()), 32'h0);
    bus.cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("midreset_no_ack%0d", i), 32'(outs()), 32'h0);
    end
    reset_n = 1'b1;
    step();
    chk("post_reset_idle", 32'(outs()), 32'h0);
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'hFD00;
    wait_ack(1'b0, 10, n);
    chk("post_reset_latency", 32'(n), 32'd3);
    chk("post_reset_data", 32'(bus.cpu_data), 32'h3E);
    step();
    bus.cpu_req = 1'b0;
    step();
    chk("final_idle", 32'(bus.busy), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
